// File: rtl/mem_arb_pkg.sv
// mem_port_arbiter shared types: FSM states, op codes, default widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 8;
   localparam int BEATS_DEF   = 4;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      WAIT_BUSY,
      WAIT_READY,
      XFER,
      DONE
   } state_t;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker; a tie goes to the port that did not win last.
module mem_arb_rr (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two cache controllers (4-beat line ops).
// Optional watchdog on the memory wait phases: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int BEATS       = BEATS_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF,
   localparam int BW         = $clog2(BEATS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_req_0,
   input  logic              rd_req_1,
   input  logic              wr_req_0,
   input  logic              wr_req_1,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [DATA_W-1:0] wdata_1,
   output logic              gnt_0,
   output logic              gnt_1,
   output logic              wbeat_0,
   output logic              wbeat_1,
   output logic              rvalid_0,
   output logic              rvalid_1,
   output logic [DATA_W-1:0] rdata,
   output logic [BW-1:0]     beat,
   output logic              done_0,
   output logic              done_1,
   output logic              err_0,
   output logic              err_1,
   output logic [ADDR_W-1:0] addr_mem,
   output logic              read_mem_enable,
   output logic              write_mem_enable,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              ready_memory
);

   state_t               state;
   state_t               state_n;
   logic [1:0]           req_q;
   logic [1:0]           wr_q;
   logic [1:0]           win;
   logic                 sel;
   op_t                  op;
   logic [ADDR_W-BW-1:0] line_q;
   logic                 last;
   logic [BW-1:0]        beat_q;
   logic [DATA_W-1:0]    rdata_q;
   logic [1:0]           rv_q;
   logic                 busy;
   logic                 xfer;
   logic                 abort;
   logic                 unused_lo;

   assign unused_lo = ^{addr_0[BW-1:0], addr_1[BW-1:0]};

   mem_arb_rr u_rr (
      .req  (req_q),
      .last (last),
      .win  (win)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] wd_cnt;
   logic [1:0]    err_q;
   logic          wait_st;
   logic          wd_hit;

   assign wait_st = (state == WAIT_BUSY) || (state == WAIT_READY);
   assign wd_hit  = wait_st && (wd_cnt == CW'(TIMEOUT_CYC - 1));
   assign err_0   = err_q[0];
   assign err_1   = err_q[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt <= '0;
         err_q  <= 2'b00;
      end else begin
         wd_cnt <= (wait_st && state_n == state) ? wd_cnt + 1'b1 : '0;
         err_q  <= abort ? {sel, ~sel} : 2'b00;
      end
   end
`else
   logic [31:0] unused_to;
   logic        wd_hit;

   assign unused_to = TIMEOUT_CYC;
   assign wd_hit    = 1'b0;
   assign err_0     = 1'b0;
   assign err_1     = 1'b0;
`endif

   always_comb begin
      state_n = state;
      abort   = 1'b0;
      unique case (state)
         IDLE:       if (|req_q_in()) state_n = ARB;
         ARB:        state_n = WAIT_BUSY;
         WAIT_BUSY:  if (!ready_memory) state_n = WAIT_READY;
         WAIT_READY: if (ready_memory) state_n = XFER;
         XFER:       if (beat_q == BW'(BEATS - 1)) state_n = DONE;
         DONE:       state_n = IDLE;
         default:    state_n = IDLE;
      endcase
      // A normal exit in the same cycle beats the watchdog.
      if (wd_hit && state_n == state) begin
         state_n = IDLE;
         abort   = 1'b1;
      end
   end

   function automatic logic [1:0] req_q_in();
      return {rd_req_1 | wr_req_1, rd_req_0 | wr_req_0};
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         req_q   <= 2'b00;
         wr_q    <= 2'b00;
         sel     <= 1'b0;
         op      <= OP_RD;
         line_q  <= '0;
         last    <= 1'b1;
         beat_q  <= '0;
         rdata_q <= '0;
         rv_q    <= 2'b00;
      end else begin
         state <= state_n;
         if (state == IDLE) begin
            req_q <= req_q_in();
            wr_q  <= {wr_req_1, wr_req_0};
         end
         if (state == ARB) begin
            sel    <= win[1];
            last   <= win[1];
            op     <= wr_q[win[1]] ? OP_WR : OP_RD;
            line_q <= win[1] ? addr_1[ADDR_W-1:BW] : addr_0[ADDR_W-1:BW];
         end
         if (xfer) beat_q <= beat_q + 1'b1;
         if (xfer && op == OP_RD) rdata_q <= mem_rdata;
         rv_q <= (xfer && op == OP_RD) ? {sel, ~sel} : 2'b00;
      end
   end

   assign busy = (state == WAIT_BUSY) || (state == WAIT_READY) ||
                 (state == XFER);
   assign xfer = (state == XFER);

   assign gnt_0            = busy & ~sel;
   assign gnt_1            = busy & sel;
   assign read_mem_enable  = busy & (op == OP_RD);
   assign write_mem_enable = busy & (op == OP_WR);
   assign wbeat_0          = xfer & (op == OP_WR) & ~sel;
   assign wbeat_1          = xfer & (op == OP_WR) & sel;
   assign done_0           = (state == DONE) & ~sel;
   assign done_1           = (state == DONE) & sel;
   assign rvalid_0         = rv_q[0];
   assign rvalid_1         = rv_q[1];
   assign rdata            = rdata_q;
   assign beat             = beat_q;
   assign addr_mem  = busy ? {line_q, (xfer ? beat_q : BW'(0))} : '0;
   assign mem_wdata = busy ? (sel ? wdata_1 : wdata_0) : '0;

endmodule
